mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 `func_MUX` output among four requesters. It drives the mux `sel` lines and returns a one-hot grant to the winning requester. It holds each grant until the owner releases or a hold limit expires, so no requester can monopolise the shared output. It sits directly in front of `func_MUX`: `sel` connects to the mux select, and `req[i]` comes from the source driving `data_in[i]`.

---
 rtl/mux_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the round-robin mux arbiter
package mux_arb_pkg;
  localparam int N_REQ        = 4;
  localparam int SEL_W        = 2;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set bit of req at or after ptr, mod 4
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  // Scan from the lowest priority down so the highest-priority hit is written last.
  always_comb begin
    any    = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = ptr + SEL_W'(i);
      if (req[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with hold limit driving the 4:1 mux select
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             expired
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  arb_state_e       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0] r_owner, w_owner_nxt;
  logic [7:0]       r_hold_cnt, w_hold_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_expired, w_expired_nxt;

  logic [N_REQ-1:0] w_pick_req;
  logic [SEL_W-1:0] w_pick_ptr;
  logic             w_pick_any;
  logic [SEL_W-1:0] w_pick_idx;
  logic [N_REQ-1:0] w_owner_oh;

  assign w_owner_oh = N_REQ'(1) << r_owner;

  // While owned, the owner bit is masked and the search starts just past it;
  // on a release the owner bit is already clear, so one pick serves both cases.
  assign w_pick_req = (r_state == OWNED) ? (req & ~w_owner_oh) : req;
  assign w_pick_ptr = (r_state == OWNED) ? (r_owner + SEL_W'(1)) : r_ptr;

  rr_pick u_pick (
    .req (w_pick_req),
    .ptr (w_pick_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_hold_nxt    = r_hold_cnt;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_expired_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = OWNED;
          w_owner_nxt = w_pick_idx;
          w_grant_nxt = N_REQ'(1) << w_pick_idx;
          w_sel_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 8'd1;
        end
      end
      OWNED: begin
        if (!req[r_owner] || (r_hold_cnt >= HOLD_LIM)) begin
          w_ptr_nxt     = r_owner + SEL_W'(1);
          w_expired_nxt = req[r_owner];
          if (w_pick_any) begin
            w_owner_nxt = w_pick_idx;
            w_grant_nxt = N_REQ'(1) << w_pick_idx;
            w_sel_nxt   = w_pick_idx;
            w_hold_nxt  = 8'd1;
          end else if (req[r_owner]) begin
            w_hold_nxt = 8'd1;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
            w_hold_nxt  = 8'd0;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_grant    <= '0;
      r_sel      <= '0;
      r_valid    <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_valid    <= w_valid_nxt;
      r_expired  <= w_expired_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign valid   = r_valid;
  assign expired = r_expired;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic       expired;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arbiter #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .valid   (valid),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic e);
    chk({tag, ".grant"},   {4'b0, grant}, {4'b0, g});
    chk({tag, ".sel"},     {6'b0, sel},   {6'b0, s});
    chk({tag, ".valid"},   {7'b0, valid}, {7'b0, v});
    chk({tag, ".expired"}, {7'b0, expired}, {7'b0, e});
  endtask

  initial begin
    logic [1:0] rot_owner;

    // Reset held with all requests asserted
    reset_n = 1'b0;
    req     = 4'b1111;
    step(); step(); step();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    reset_n = 1'b1;
    step();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("release_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester, held four cycles then dropped
    req = 4'b0100;
    step();
    chk_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); step(); step();
    chk_out("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("single_drop", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Full contention rotation from a fresh reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req     = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      rot_owner = 2'(k);
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("rot_k%0d_c%0d.grant", k, c), {4'b0, grant}, {4'b0, 4'b0001 << rot_owner});
        chk($sformatf("rot_k%0d_c%0d.sel", k, c), {6'b0, sel}, {6'b0, rot_owner});
        chk($sformatf("rot_k%0d_c%0d.expired", k, c), {7'b0, expired},
            {7'b0, (c == 0 && k != 0)});
        chk($sformatf("rot_k%0d_c%0d.onehot", k, c), {7'b0, $onehot0(grant)}, 8'd1);
        step();
      end
    end

    // Owner 3 releases with 0 and 1 pending: ptr wraps, no idle cycle
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req     = 4'b1000;
    step();
    chk_out("ho_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1011;
    step();
    chk_out("ho_nonowner_change", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0011;
    step();
    chk_out("ho_wrap_to0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Lone owner re-granted on each expiry
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req     = 4'b0010;
    for (int n = 0; n < 20; n++) begin
      step();
      chk($sformatf("lone_n%0d.grant", n), {4'b0, grant}, 8'h02);
      chk($sformatf("lone_n%0d.expired", n), {7'b0, expired}, {7'b0, (n == 8 || n == 16)});
    end

    // Reset while owner 2 is at hold_cnt 5
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req     = 4'b0100;
    for (int n = 0; n < 5; n++) step();
    chk_out("mid_before", 4'b0100, 2'd2, 1'b1, 1'b0);
    reset_n = 1'b0;
    step();
    chk_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    req     = 4'b0110;
    step();
    chk_out("mid_after", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
